// File: rtl/hyperCord_pkg.sv
// Shared types, width defaults and saturation helpers for the hyperbolic CORDIC datapath.
// HYPERCORD_ADDSUB_SAT_EN selects saturating instead of wrapping results in fixed_addsub_lane.
package hyperCord_pkg;

  localparam int I_SIGN_WIDTH = 1;
  localparam int I_INT_WIDTH  = 3;
  localparam int I_FRA_WIDTH  = 12;
  localparam int IDWIDTH      = I_SIGN_WIDTH + I_INT_WIDTH + I_FRA_WIDTH;

  localparam int ADDSUB_PIPE_MIN = 1;
  localparam int ADDSUB_PIPE_MAX = 4;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } addsub_mode_e;

  // Returned 64 bits wide; callers keep the low DWIDTH bits.
  function automatic logic [63:0] sat_max(input int dw);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      if (i < dw - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [63:0] sat_min(input int dw);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i == dw - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_addsub_lane.sv
// Combinational single-lane two's-complement add/sub with signed overflow detection.
// With HYPERCORD_ADDSUB_SAT_EN defined an overflowing lane saturates; otherwise it wraps.
module fixed_addsub_lane
  import hyperCord_pkg::*;
#(
  parameter int DWIDTH = IDWIDTH
) (
  input  logic              iMode,
  input  logic [DWIDTH-1:0] iA,
  input  logic [DWIDTH-1:0] iB,
  output logic [DWIDTH-1:0] oSum,
  output logic              oOvf
);

  logic              w_sub;
  logic [DWIDTH:0]   w_aExt;
  logic [DWIDTH:0]   w_bExt;
  logic [DWIDTH:0]   w_sum;

  // Subtraction reuses the adder: invert B and inject the +1 as carry-in.
  assign w_sub  = (addsub_mode_e'(iMode) == SUB);
  assign w_aExt = {iA[DWIDTH-1], iA};
  assign w_bExt = w_sub ? ~{iB[DWIDTH-1], iB} : {iB[DWIDTH-1], iB};
  assign w_sum  = w_aExt + w_bExt + {{DWIDTH{1'b0}}, w_sub};
  assign oOvf   = w_sum[DWIDTH] ^ w_sum[DWIDTH-1];

`ifdef HYPERCORD_ADDSUB_SAT_EN
  localparam logic [63:0] SAT_MAX = sat_max(DWIDTH);
  localparam logic [63:0] SAT_MIN = sat_min(DWIDTH);

  assign oSum = !oOvf         ? w_sum[DWIDTH-1:0] :
                w_sum[DWIDTH] ? SAT_MIN[DWIDTH-1:0] : SAT_MAX[DWIDTH-1:0];
`else
  assign oSum = w_sum[DWIDTH-1:0];
`endif

endmodule

// File: rtl/fixed_addsub_pipe.sv
// Pipelined multi-lane fixed-point add/sub with valid/ready handshake and per-lane overflow.
// Saturation is selected at build time by HYPERCORD_ADDSUB_SAT_EN.
module fixed_addsub_pipe
  import hyperCord_pkg::*;
#(
  parameter int INT_WIDTH  = I_INT_WIDTH,
  parameter int FRA_WIDTH  = I_FRA_WIDTH,
  parameter int SIGN_WIDTH = I_SIGN_WIDTH,
  parameter int DWIDTH     = IDWIDTH,
  parameter int LANES      = 1,
  parameter int PIPE       = 2
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [LANES-1:0]        iMode,
  input  logic [LANES*DWIDTH-1:0] iData1,
  input  logic [LANES*DWIDTH-1:0] iData2,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [LANES*DWIDTH-1:0] oData,
  output logic [LANES-1:0]        oOvf
);

  if (SIGN_WIDTH != 1) begin : g_badSign
    $error("fixed_addsub_pipe: SIGN_WIDTH must be 1");
  end
  if (DWIDTH != SIGN_WIDTH + INT_WIDTH + FRA_WIDTH) begin : g_badWidth
    $error("fixed_addsub_pipe: DWIDTH must equal SIGN_WIDTH+INT_WIDTH+FRA_WIDTH");
  end
  if (PIPE < ADDSUB_PIPE_MIN || PIPE > ADDSUB_PIPE_MAX) begin : g_badPipe
    $error("fixed_addsub_pipe: PIPE out of range 1..4");
  end

  logic [LANES*DWIDTH-1:0] w_sum;
  logic [LANES-1:0]        w_ovf;
  logic [PIPE-1:0]         w_adv;

  logic [PIPE-1:0]         r_valid;
  logic [LANES*DWIDTH-1:0] r_data [PIPE];
  logic [LANES-1:0]        r_ovf  [PIPE];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fixed_addsub_lane #(
      .DWIDTH (DWIDTH)
    ) u_lane (
      .iMode (iMode[k]),
      .iA    (iData1[k*DWIDTH +: DWIDTH]),
      .iB    (iData2[k*DWIDTH +: DWIDTH]),
      .oSum  (w_sum[k*DWIDTH +: DWIDTH]),
      .oOvf  (w_ovf[k])
    );
  end

  // A stage moves when any stage at or after it is empty, or the output is consumed.
  for (genvar s = 0; s < PIPE; s++) begin : g_adv
    assign w_adv[s] = iReady | ~(&r_valid[PIPE-1:s]);
  end

  assign oReady = w_adv[0];
  assign oValid = r_valid[PIPE-1];
  assign oData  = r_data[PIPE-1];
  assign oOvf   = r_ovf[PIPE-1];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_valid <= '0;
      for (int s = 0; s < PIPE; s++) begin
        r_data[s] <= '0;
        r_ovf[s]  <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= iValid;
        if (iValid) begin
          r_data[0] <= w_sum;
          r_ovf[0]  <= w_ovf;
        end
      end
      for (int s = 1; s < PIPE; s++) begin
        if (w_adv[s]) begin
          r_valid[s] <= r_valid[s-1];
          r_data[s]  <= r_data[s-1];
          r_ovf[s]   <= r_ovf[s-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_addsub_pipe.sv
// Scoreboard bench for fixed_addsub_pipe (DWIDTH=16, LANES=4, PIPE=3), randomized against an integer model.
// Expected results follow HYPERCORD_ADDSUB_SAT_EN when the bench is built with it.
module tb_fixed_addsub_pipe;

  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int PIPE  = 3;

  typedef struct packed {
    logic [LANES*DW-1:0] d;
    logic [LANES-1:0]    o;
  } exp_t;

  logic                iClk = 1'b0;
  logic                iRst_n = 1'b0;
  logic                iValid = 1'b0;
  logic                iReady = 1'b1;
  logic [LANES-1:0]    iMode = '0;
  logic [LANES*DW-1:0] iData1 = '0;
  logic [LANES*DW-1:0] iData2 = '0;
  logic                oReady;
  logic                oValid;
  logic [LANES*DW-1:0] oData;
  logic [LANES-1:0]    oOvf;

  int   nTests = 0;
  int   nFail = 0;
  exp_t sb[$];
  int   cyc = 0;
  int   streamStart = 0;
  int   readyCtl = 0;
  int   occ = 0;
  bit   heldV = 1'b0;
  exp_t held;

  fixed_addsub_pipe #(
    .DWIDTH (DW),
    .LANES  (LANES),
    .PIPE   (PIPE)
  ) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iValid (iValid),
    .oReady (oReady),
    .iMode  (iMode),
    .iData1 (iData1),
    .iData2 (iData2),
    .oValid (oValid),
    .iReady (iReady),
    .oData  (oData),
    .oOvf   (oOvf)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain signed integer arithmetic; overflow means the true result leaves the 16-bit range.
  function automatic exp_t refModel(input logic [LANES-1:0] mode,
                                    input logic [LANES*DW-1:0] a,
                                    input logic [LANES*DW-1:0] b);
    exp_t e;
    int av, bv, r;
    logic ovf;
    logic [DW-1:0] res;
    e = '0;
    for (int k = 0; k < LANES; k++) begin
      av  = int'($signed(a[k*DW +: DW]));
      bv  = int'($signed(b[k*DW +: DW]));
      r   = mode[k] ? av - bv : av + bv;
      ovf = (r > 32767) || (r < -32768);
      res = DW'(r);
`ifdef HYPERCORD_ADDSUB_SAT_EN
      if (ovf) res = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
      e.d[k*DW +: DW] = res;
      e.o[k] = ovf;
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] pickVal();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  // Must be entered after a rising edge; returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [LANES-1:0] mode,
                               input logic [LANES*DW-1:0] a,
                               input logic [LANES*DW-1:0] b);
    iValid = 1'b1;
    iMode  = mode;
    iData1 = a;
    iData2 = b;
    for (int t = 0; t < 500; t++) begin
      @(negedge iClk);
      if (oReady) begin
        sb.push_back(refModel(mode, a, b));
        @(posedge iClk);
        #1;
        return;
      end
      @(posedge iClk);
      #1;
    end
    nTests++;
    nFail++;
    $display("[TB] FAIL acceptTimeout: got no oReady expected oReady within 500 cycles");
  endtask

  task automatic applyRandom();
    logic [LANES*DW-1:0] a, b;
    for (int k = 0; k < LANES; k++) begin
      a[k*DW +: DW] = pickVal();
      b[k*DW +: DW] = pickVal();
    end
    applyStimulus(LANES'($urandom), a, b);
  endtask

  task automatic idle(input int n);
    iValid = 1'b0;
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic drain();
    iValid = 1'b0;
    for (int t = 0; t < 400 && sb.size() != 0; t++) begin
      @(posedge iClk);
      #1;
    end
    checkOutput("drainEmpty", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    iReady = 1'b1;
    forever begin
      @(posedge iClk);
      #1;
      cyc++;
      case (readyCtl)
        1: iReady = ((cyc - streamStart) >= 4 && (cyc - streamStart) <= 7) ? 1'b0 : 1'($urandom_range(0, 1));
        2: iReady = ($urandom_range(0, 3) != 0);
        default: iReady = 1'b1;
      endcase
    end
  end

  // Monitor: ready rule, stall stability and in-order scoreboard checks, all sampled on the falling edge.
  always @(negedge iClk) begin
    exp_t e;
    if (!iRst_n) begin
      occ   = 0;
      heldV = 1'b0;
    end else begin
      checkOutput("oReady", 128'(oReady), 128'(iReady || occ < PIPE));
      if (heldV) begin
        checkOutput("stallValid", 128'(oValid), 128'(1));
        checkOutput("stallHold", 128'({oData, oOvf}), 128'(held));
      end
      if (oValid && iReady) begin
        if (sb.size() == 0) begin
          nTests++;
          nFail++;
          $display("[TB] FAIL unexpectedOutput: got %0h expected no output", oData);
        end else begin
          e = sb.pop_front();
          checkOutput("result", 128'({oData, oOvf}), 128'(e));
        end
      end
      occ   = occ + int'(iValid && oReady) - int'(oValid && iReady);
      heldV = oValid && !iReady;
      held  = '{d: oData, o: oOvf};
    end
  end

  initial begin
    int lat;
    iRst_n = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    checkOutput("resetValid", 128'(oValid), 128'(0));
    checkOutput("resetData", 128'(oData), 128'(0));
    checkOutput("resetOvf", 128'(oOvf), 128'(0));
    iRst_n = 1'b1;
    idle(2);

    // Result must appear PIPE falling edges after the accepting rising edge.
    applyStimulus(4'b0000, {16'h0, 16'h0, 16'h0, 16'h1234}, {16'h0, 16'h0, 16'h0, 16'h0111});
    iValid = 1'b0;
    lat = 0;
    for (int t = 1; t <= 10; t++) begin
      @(negedge iClk);
      if (oValid) begin
        lat = t;
        break;
      end
    end
    checkOutput("latency", 128'(lat), 128'(PIPE));
    idle(4);

    applyStimulus(4'b0000, {16'h0, 16'h0, 16'h7FFF, 16'h1234}, {16'h0, 16'h0, 16'h0001, 16'h0111});
    applyStimulus(4'b1111, {16'h0, 16'h8000, 16'h0000, 16'h8000}, {16'h0, 16'h8000, 16'h8000, 16'h0001});
    applyStimulus(4'b0101, {16'hFFFE, 16'hFFFE, 16'h0005, 16'h0005}, {16'h0007, 16'h0007, 16'h0003, 16'h0003});
    drain();

    streamStart = cyc;
    readyCtl = 1;
    for (int i = 0; i < 10; i++) applyRandom();
    drain();

    readyCtl = 2;
    for (int i = 0; i < 150; i++) begin
      applyRandom();
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    readyCtl = 0;
    idle(2);
    applyRandom();
    applyRandom();
    iValid = 1'b0;
    @(posedge iClk);
    #1;
    checkOutput("preResetValid", 128'(oValid), 128'(1));
    #1;
    iRst_n = 1'b0;
    #1;
    checkOutput("asyncResetValid", 128'(oValid), 128'(0));
    checkOutput("asyncResetData", 128'(oData), 128'(0));
    sb.delete();
    @(posedge iClk);
    @(posedge iClk);
    #2;
    iRst_n = 1'b1;
    @(negedge iClk);
    checkOutput("oReadyAfterReset", 128'(oReady), 128'(1));
    checkOutput("noStaleValid", 128'(oValid), 128'(0));
    @(posedge iClk);
    #1;
    idle(10);
    checkOutput("finalEmpty", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/fixed_addsub_pipe.md
Name: fixed_addsub_pipe

Overview:
- Pipelined, multi-lane, two's-complement fixed-point adder/subtractor with a per-lane runtime add/sub select.
- Carries a valid/ready handshake and overflow detection.
- Successor to the single-mode combinational add/sub primitive.
- Used as the shared X/Y/Z update datapath for hyperbolic CORDIC iteration stages and the post-scale accumulators.

Parameters:
- INT_WIDTH, I_INT_WIDTH: integer bits per operand, sign excluded.
- FRA_WIDTH, I_FRA_WIDTH: fractional bits per operand.
- SIGN_WIDTH, I_SIGN_WIDTH: sign bits; 1 is the only legal value.
- DWIDTH, IDWIDTH: operand width; must equal SIGN_WIDTH+INT_WIDTH+FRA_WIDTH. Elaboration error on mismatch.
- LANES, 1: independent operand pairs processed per transaction.
- PIPE, 2: latency in cycles, legal range 1..4. Elaboration error outside range.

Ports:
- iClk  input  1  clock.
- iRst_n  input  1  asynchronous active-low reset.
- iValid  input  1  upstream transaction valid.
- oReady  output  1  block can accept a transaction this cycle.
- iMode  input  LANES  per-lane select: 0 = add, 1 = subtract (iData1 - iData2).
- iData1  input  LANES*DWIDTH  packed operand A; lane k at [k*DWIDTH +: DWIDTH].
- iData2  input  LANES*DWIDTH  packed operand B; same packing.
- oValid  output  1  result valid.
- iReady  input  1  downstream accepts the result.
- oData  output  LANES*DWIDTH  packed results.
- oOvf  output  LANES  per-lane signed overflow flag, aligned with oData.

Behaviour:
- Clock and reset: one clock iClk. Reset iRst_n is asynchronous, active-low.
- Reset values: all stage valid bits 0, oValid 0, oData 0, oOvf 0. oReady reads 1 once reset deasserts.
- Reset mid-operation: all in-flight transactions are discarded and nothing is emitted afterwards. Data registers may clear, but only the valid bits are required to clear.
- Handshake:
  - A transfer occurs on a rising edge where both iValid and oReady are 1.
  - An output is consumed on a rising edge where both oValid and iReady are 1.
  - While oValid=1 and iReady=0, oData and oOvf hold stable.
  - oValid never drops without a consume, except on reset.
- Pipeline: PIPE register stages v[0..PIPE-1], each holding a valid bit and payload.
  - Stage s advances when v[s] is empty, or when stage s+1 advances (the last stage advances on iReady).
  - oReady = !v[0] || advance(0). This is a combinational ready chain; no skid buffer.
  - Full throughput of 1 transaction/cycle while iReady=1.
  - Latency from accept edge to oValid = PIPE cycles.
  - Bubbles collapse: a stalled output with an empty earlier stage still accepts input.
- Arithmetic per lane (no lane interaction):
  - Subtract is A + (~B) + 1 with a carry-in, not a separate negate.
  - Operands are sign-extended to DWIDTH+1 and the raw sum is computed.
  - Compute happens in stage 0. The remaining stages only delay the result.
  - Overflow: ovf = (sum[DWIDTH] != sum[DWIDTH-1]).
  - Default result = sum[DWIDTH-1:0], i.e. modular wrap.
  - Fixed-point scaling is unchanged: the binary point stays at FRA_WIDTH and no rounding is applied.
- Edge cases:
  - A - MIN (e.g. 0 - 0x8000) overflows and is flagged.
  - MIN - MIN = 0 with no overflow.
  - Mode applies only to the transaction it arrives with. Lanes may mix modes within one transaction.
- Simultaneous events: a full pipeline with consume and accept on the same edge shifts all stages with no loss or duplication. iValid with oReady=0 is held off; the caller must keep the inputs stable.

Optional Feature:
- HYPERCORD_ADDSUB_SAT_EN defined:
  - A lane with ovf=1 outputs the saturated value: max positive (0 followed by all 1s) when sum[DWIDTH]=0, otherwise min negative (1 followed by all 0s).
  - oOvf still reports overflow.
- Macro undefined: result wraps modulo 2^DWIDTH and oOvf still reports overflow.
- Port list and latency are identical in both builds.

Decomposition:
- hyperCord_pkg gets:
  - typedef addsub_mode_e {ADD=0, SUB=1};
  - localparams ADDSUB_PIPE_MIN=1 and ADDSUB_PIPE_MAX=4;
  - functions sat_max(DWIDTH) and sat_min(DWIDTH).
- Existing I_* width constants are reused as parameter defaults.
- One natural sub-module, fixed_addsub_lane: combinational per-lane add/sub, overflow and saturation, instantiated LANES times by generate.
- Handshake and pipeline registers stay in the top module.

Test Plan:
- DWIDTH=16, PIPE=2, LANES=1, add 0x1234+0x0111 with iReady=1: 0x1345 and oOvf=0 appear with oValid=1 exactly 2 cycles after the accept edge.
- Add 0x7FFF+0x0001: wrap build gives 0x8000, oOvf=1; SAT_EN build gives 0x7FFF, oOvf=1. Subtract 0x8000-0x0001: wrap gives 0x7FFF, sat gives 0x8000, oOvf=1.
- Subtract 0x0000-0x8000 gives oOvf=1 (sat build 0x7FFF). Subtract 0x8000-0x8000 gives 0x0000, oOvf=0.
- LANES=4, iMode=4'b0101, lanes (5,3)/(5,3)/(-2,7)/(-2,7): outputs 2, 8, -9, 5 in one beat.
- PIPE=3, stream 10 back-to-back transactions, iReady low for cycles 4-7 then random: all 10 results arrive in order with no loss or duplicate. oReady drops only once all 3 stages are full. oData stays stable while stalled.
- Assert iRst_n low with 2 transactions in flight: oValid is 0 immediately (asynchronous). After release no stale result appears, and oReady=1 on the first cycle.
